// File: rtl/ctrl_clave_crono_pkg.sv
// Shared definitions for the keypad / timer controller.
// Keypad state encodings and key-code constants.
package ctrl_clave_crono_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'b00,
        CAPTURA = 2'b01,
        BLOQUEO = 2'b10
    } kp_state_t;

    localparam logic [3:0] TECLA_MAX_DIG = 4'd9;

    function automatic logic es_digito(input logic [3:0] t);
        return t <= TECLA_MAX_DIG;
    endfunction

endpackage

// File: rtl/ctrl_clave_crono_cronometro.sv
// Timer: ro rises T_CRONO edges after the inicio edge.
// Stays high until parar, a new inicio, or reset.
module cronometro #(
    parameter int T_CRONO = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic inicio,
    input  logic parar,
    output logic ro
);
    import ctrl_clave_crono_pkg::*;

    localparam int CW = $clog2(T_CRONO + 1);
    localparam logic [CW-1:0] CARGA = CW'(T_CRONO);
    localparam logic [CW-1:0] UNO   = CW'(1);

    logic [CW-1:0] cnt;
    logic          run;

    // Down-counter loaded on inicio; raises ro when the last count elapses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
            ro  <= 1'b0;
        end else if (inicio) begin
            cnt <= CARGA;
            run <= 1'b1;
            ro  <= 1'b0;
        end else if (parar) begin
            cnt <= '0;
            run <= 1'b0;
            ro  <= 1'b0;
        end else if (run) begin
            if (cnt == UNO) begin
                cnt <= '0;
                run <= 1'b0;
                ro  <= 1'b1;
            end else begin
                cnt <= cnt - UNO;
            end
        end
    end

endmodule

// File: rtl/ctrl_clave_crono.sv
// Password and timer controller for the security FSM.
// Captures keypad digits, checks the code, locks out after repeated failures.
module ctrl_clave_crono #(
    parameter int N_DIGITOS = 4,
    parameter logic [4*N_DIGITOS-1:0] CLAVE = 16'h1234,
    parameter int T_CRONO = 50,
    parameter int MAX_INTENTOS = 3,
    parameter int T_BLOQUEO = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tecla_valida,
    input  logic [3:0] tecla,
    input  logic       enter,
    input  logic       borrar,
    input  logic       inicio_crono,
    input  logic       parar_crono,
    output logic       pw,
    output logic       ro,
    output logic       error,
    output logic       bloqueado,
    output logic [3:0] n_dig
);
    import ctrl_clave_crono_pkg::*;

    localparam int BUFW = 4 * N_DIGITOS;
    localparam int IW   = $clog2(MAX_INTENTOS + 1);
    localparam int BW   = $clog2(T_BLOQUEO + 1);

    localparam logic [3:0]    NMAX  = 4'(N_DIGITOS);
    localparam logic [IW-1:0] ULT   = IW'(MAX_INTENTOS - 1);
    localparam logic [IW-1:0] I_UNO = IW'(1);
    localparam logic [BW-1:0] BCARGA = BW'(T_BLOQUEO);
    localparam logic [BW-1:0] B_UNO  = BW'(1);

    kp_state_t     state;
    logic [BUFW-1:0] buffer;
    logic [IW-1:0] intentos;
    logic [BW-1:0] cnt_blq;

    // Keypad FSM: digit capture, code check, failure count and lockout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ESPERA;
            buffer    <= '0;
            intentos  <= '0;
            cnt_blq   <= '0;
            n_dig     <= 4'd0;
            pw        <= 1'b0;
            error     <= 1'b0;
            bloqueado <= 1'b0;
        end else begin
            pw    <= 1'b0;
            error <= 1'b0;
            case (state)
                BLOQUEO: begin
                    if (cnt_blq == B_UNO) begin
                        state     <= ESPERA;
                        bloqueado <= 1'b0;
                        intentos  <= '0;
                        cnt_blq   <= '0;
                    end else begin
                        cnt_blq <= cnt_blq - B_UNO;
                    end
                end
                default: begin
                    if (borrar) begin
                        buffer <= '0;
                        n_dig  <= 4'd0;
                        state  <= ESPERA;
                    end else if (enter) begin
                        buffer <= '0;
                        n_dig  <= 4'd0;
                        state  <= ESPERA;
                        if (n_dig == NMAX && buffer == CLAVE) begin
                            pw       <= 1'b1;
                            intentos <= '0;
                        end else if (intentos == ULT) begin
                            error     <= 1'b1;
                            bloqueado <= 1'b1;
                            cnt_blq   <= BCARGA;
                            state     <= BLOQUEO;
                        end else begin
                            error    <= 1'b1;
                            intentos <= intentos + I_UNO;
                        end
                    end else if (tecla_valida && es_digito(tecla)
                                 && n_dig < NMAX) begin
                        buffer <= (buffer << 4) | BUFW'(tecla);
                        n_dig  <= n_dig + 4'd1;
                        state  <= CAPTURA;
                    end
                end
            endcase
        end
    end

    cronometro #(
        .T_CRONO (T_CRONO)
    ) u_crono (
        .clk    (clk),
        .rst    (rst),
        .inicio (inicio_crono),
        .parar  (parar_crono),
        .ro     (ro)
    );

endmodule

// File: tb/tb_ctrl_clave_crono.sv
// Directed bench for ctrl_clave_crono with an expectation queue.
module tb_ctrl_clave_crono;

    logic       clk = 1'b0;
    logic       rst;
    logic       tecla_valida;
    logic [3:0] tecla;
    logic       enter;
    logic       borrar;
    logic       inicio_crono;
    logic       parar_crono;
    logic       pw;
    logic       ro;
    logic       error;
    logic       bloqueado;
    logic [3:0] n_dig;

    ctrl_clave_crono dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_valida (tecla_valida),
        .tecla        (tecla),
        .enter        (enter),
        .borrar       (borrar),
        .inicio_crono (inicio_crono),
        .parar_crono  (parar_crono),
        .pw           (pw),
        .ro           (ro),
        .error        (error),
        .bloqueado    (bloqueado),
        .n_dig        (n_dig)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         kp;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   k;
    int   m;
    int   lock_cyc;

    task automatic exp_kp(input string tag, input logic p, input logic e,
                          input logic b, input logic [3:0] n);
        exp_t x;
        x.tag = tag;
        x.kp  = 1'b1;
        x.val = {1'b0, p, e, b, n};
        sb.push_back(x);
    endtask

    task automatic exp_ro(input string tag, input logic r);
        exp_t x;
        x.tag = tag;
        x.kp  = 1'b0;
        x.val = {7'b0, r};
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            obs = x.kp ? {1'b0, pw, error, bloqueado, n_dig} : {7'b0, ro};
            n_chk++;
            assert (obs === x.val) n_pass++;
            else $error("FAIL %s: observed %h expected %h",
                        x.tag, obs, x.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        tecla_valida = 1'b0;
        enter        = 1'b0;
        borrar       = 1'b0;
        inicio_crono = 1'b0;
        parar_crono  = 1'b0;
        drain();
    endtask

    task automatic key(input logic [3:0] t, input string tag,
                       input logic [3:0] n, input logic b);
        tecla_valida = 1'b1;
        tecla        = t;
        exp_kp(tag, 1'b0, 1'b0, b, n);
        tick();
    endtask

    task automatic press_enter(input string tag, input logic p,
                               input logic e, input logic b);
        enter = 1'b1;
        exp_kp(tag, p, e, b, 4'd0);
        tick();
    endtask

    task automatic fail_try(input string tag, input logic b_after);
        key(4'd1, {tag, "_k1"}, 4'd1, 1'b0);
        key(4'd2, {tag, "_k2"}, 4'd2, 1'b0);
        key(4'd3, {tag, "_k3"}, 4'd3, 1'b0);
        key(4'd5, {tag, "_k4"}, 4'd4, 1'b0);
        press_enter({tag, "_ent"}, 1'b0, 1'b1, b_after);
    endtask

    initial begin
        rst          = 1'b0;
        tecla_valida = 1'b0;
        tecla        = 4'd0;
        enter        = 1'b0;
        borrar       = 1'b0;
        inicio_crono = 1'b0;
        parar_crono  = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_kp("rst_kp", 1'b0, 1'b0, 1'b0, 4'd0);
        exp_ro("rst_ro", 1'b0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        exp_kp("idle0", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // correct code
        key(4'd1, "ok_k1", 4'd1, 1'b0);
        key(4'd2, "ok_k2", 4'd2, 1'b0);
        key(4'd3, "ok_k3", 4'd3, 1'b0);
        key(4'd4, "ok_k4", 4'd4, 1'b0);
        press_enter("ok_ent", 1'b1, 1'b0, 1'b0);
        exp_kp("ok_after", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // three failures lock the keypad
        fail_try("f1", 1'b0);
        fail_try("f2", 1'b0);
        fail_try("f3", 1'b1);
        lock_cyc = cyc;
        exp_kp("lk_idle", 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        key(4'd1, "lk_k1", 4'd0, 1'b1);
        key(4'd2, "lk_k2", 4'd0, 1'b1);
        key(4'd3, "lk_k3", 4'd0, 1'b1);
        key(4'd4, "lk_k4", 4'd0, 1'b1);
        press_enter("lk_ent", 1'b0, 1'b0, 1'b1);
        while (cyc < lock_cyc + 98) tick();
        exp_kp("lk_99", 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        exp_kp("lk_end", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // fifth key ignored, non-digit ignored
        key(4'd1, "x_k1", 4'd1, 1'b0);
        key(4'hB, "x_kB", 4'd1, 1'b0);
        key(4'd2, "x_k2", 4'd2, 1'b0);
        key(4'd3, "x_k3", 4'd3, 1'b0);
        key(4'd4, "x_k4", 4'd4, 1'b0);
        key(4'd7, "x_k7", 4'd4, 1'b0);
        press_enter("x_ent", 1'b1, 1'b0, 1'b0);

        // borrar mid-entry
        key(4'd1, "b_k1", 4'd1, 1'b0);
        key(4'd2, "b_k2", 4'd2, 1'b0);
        borrar = 1'b1;
        exp_kp("b_clr", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        key(4'd3, "b_k3", 4'd1, 1'b0);
        key(4'd4, "b_k4", 4'd2, 1'b0);
        press_enter("b_ent", 1'b0, 1'b1, 1'b0);

        // enter with borrar in the same cycle
        key(4'd1, "eb_k1", 4'd1, 1'b0);
        key(4'd2, "eb_k2", 4'd2, 1'b0);
        key(4'd3, "eb_k3", 4'd3, 1'b0);
        key(4'd4, "eb_k4", 4'd4, 1'b0);
        borrar = 1'b1;
        press_enter("eb_ent", 1'b0, 1'b0, 1'b0);
        key(4'd1, "c_k1", 4'd1, 1'b0);
        key(4'd2, "c_k2", 4'd2, 1'b0);
        key(4'd3, "c_k3", 4'd3, 1'b0);
        key(4'd4, "c_k4", 4'd4, 1'b0);
        press_enter("c_ent", 1'b1, 1'b0, 1'b0);

        // timer start, restart, stop
        inicio_crono = 1'b1;
        exp_ro("t_ini", 1'b0);
        tick();
        k = cyc;
        while (cyc < k + 19) tick();
        inicio_crono = 1'b1;
        tick();
        while (cyc < k + 49) tick();
        exp_ro("t_50", 1'b0);
        tick();
        while (cyc < k + 68) tick();
        exp_ro("t_69", 1'b0);
        tick();
        exp_ro("t_70", 1'b1);
        tick();
        while (cyc < k + 78) tick();
        exp_ro("t_79", 1'b1);
        tick();
        parar_crono = 1'b1;
        exp_ro("t_stop", 1'b0);
        tick();

        // inicio and parar together restart the timer
        inicio_crono = 1'b1;
        tick();
        m = cyc;
        while (cyc < m + 9) tick();
        inicio_crono = 1'b1;
        parar_crono  = 1'b1;
        exp_ro("ip_10", 1'b0);
        tick();
        while (cyc < m + 49) tick();
        exp_ro("ip_50", 1'b0);
        tick();
        while (cyc < m + 59) tick();
        exp_ro("ip_60", 1'b1);
        tick();

        // reset mid-entry clears attempts and ro
        fail_try("r1", 1'b0);
        fail_try("r2", 1'b0);
        key(4'd1, "r_k1", 4'd1, 1'b0);
        key(4'd2, "r_k2", 4'd2, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_kp("rst_mid", 1'b0, 1'b0, 1'b0, 4'd0);
        exp_ro("rst_mid_ro", 1'b0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        fail_try("a1", 1'b0);
        fail_try("a2", 1'b0);
        fail_try("a3", 1'b1);
        repeat (5) tick();

        // reset mid-lockout
        #2 rst = 1'b1;
        #1;
        exp_kp("rst_lk", 1'b0, 1'b0, 1'b0, 4'd0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        fail_try("z1", 1'b0);
        fail_try("z2", 1'b0);
        exp_kp("z_idle", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
